alu_transpose_seq_module: RTL and testbench

ALU_TRANSPOSE_SEQ_MODULE -- requirements
Module: alu_transpose_seq_module

---
 rtl/alu_transpose_seq_module.sv | 160 ++++++++++++++++
 tb/tb_alu_transpose_seq_module.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_transpose_seq_module.sv
// -----------------------------------------------------------------------------
// alu_transpose_seq_module
//
// Sequential matrix transpose. A start pulse in IDLE captures an N x N operand
// (row-major, DW bits per element) and an active dimension S. The engine then
// copies one element per cycle, C[r][c] <= A[c][r], over the S x S active
// window. Everything outside that window stays zero. A single-cycle done pulse
// marks completion. An out-of-range S (0 or >N) skips the copy, raises size_err
// and completes at once.
//
// Parameters
//   DW  element width in bits (elements are copied verbatim)
//   N   maximum matrix dimension (2..7)
//   SW  width of the size port, 2**SW > N
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request pulse, only looked at in IDLE
//   size      active dimension S, sampled with start
//   A_flat    source matrix, element (r,c) at [(r*N+c)*DW +: DW]
//   C_flat    registered result, same packing as A_flat
//   busy      high in every state except IDLE
//   done      one-cycle completion pulse
//   size_err  set when the accepted size is illegal, held until next accept
// -----------------------------------------------------------------------------
module alu_transpose_seq_module #(
  parameter int DW = 8,
  parameter int N  = 5,
  parameter int SW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SW-1:0]     size,
  input  logic [N*N*DW-1:0] A_flat,
  output logic [N*N*DW-1:0] C_flat,
  output logic              busy,
  output logic              done,
  output logic              size_err
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   opnd_q [N][N];
  logic [DW-1:0]   res_q  [N][N];
  logic [IW-1:0]   row_q;
  logic [IW-1:0]   col_q;
  logic [IW-1:0]   last_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  // Legal dimensions are 1..N; the size port is wide enough to encode more.
  function automatic logic size_valid(input logic [SW-1:0] sz);
    return (sz != '0) && (sz <= SW'(N));
  endfunction

  // Highest active index S-1. Only meaningful for a legal S, which always
  // fits in IW bits because S <= N.
  function automatic logic [IW-1:0] last_index(input logic [SW-1:0] sz);
    logic [SW-1:0] m1;
    m1 = sz - SW'(1);
    return IW'(m1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          opnd_q[r][c] <= '0;
          res_q[r][c]  <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Snapshot the operand so later changes on A_flat/size are inert.
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                opnd_q[r][c] <= A_flat[(r*N+c)*DW +: DW];
                res_q[r][c]  <= '0;
              end
            end
            row_q  <= '0;
            col_q  <= '0;
            last_q <= last_index(size);
            busy_q <= 1'b1;
            if (size_valid(size)) begin
              err_q   <= 1'b0;
              state_q <= COPY;
            end else begin
              // Illegal size: finish immediately with the error flag.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end

        COPY: begin
          res_q[row_q][col_q] <= opnd_q[col_q][row_q];
          if (col_q == last_q) begin
            col_q <= '0;
            if (row_q == last_q) begin
              // This edge writes (S-1,S-1): the copy is complete.
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              row_q <= row_q + IW'(1);
            end
          end else begin
            col_q <= col_q + IW'(1);
          end
        end

        FIN: begin
          // start is deliberately ignored here; a new request is taken on
          // the first IDLE cycle.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      assign C_flat[(gr*N+gc)*DW +: DW] = res_q[gr][gc];
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign size_err = err_q;

endmodule

// File: tb/tb_alu_transpose_seq_module.sv
module tb_alu_transpose_seq_module;

  localparam int DW = 8;
  localparam int N  = 5;
  localparam int SW = 3;
  localparam int W  = N*N*DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] size = '0;
  logic [W-1:0]  A_flat = '0;
  logic [W-1:0]  C_flat;
  logic          busy;
  logic          done;
  logic          size_err;

  alu_transpose_seq_module #(.DW(DW), .N(N), .SW(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .size     (size),
    .A_flat   (A_flat),
    .C_flat   (C_flat),
    .busy     (busy),
    .done     (done),
    .size_err (size_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] c;
    logic         err;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks  = 0;
  int errors  = 0;
  int accepts = 0;
  int dones   = 0;

  function automatic void chk_vec(string nm, logic [W-1:0] act, logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  function automatic void chk_int(string nm, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  // A(r,c) = 5r+c
  function automatic logic [W-1:0] lin_a();
    logic [W-1:0] a = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        a[(r*N+c)*DW +: DW] = DW'(5*r + c);
    return a;
  endfunction

  // Hand formula for the transpose of lin_a over an S window: 5c+r, zero outside.
  function automatic logic [W-1:0] lin_exp(int s);
    logic [W-1:0] e = '0;
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++)
        e[(r*N+c)*DW +: DW] = DW'(5*c + r);
    return e;
  endfunction

  function automatic logic [W-1:0] pat_a(int j);
    logic [W-1:0] a = '0;
    for (int i = 0; i < N*N; i++)
      a[i*DW +: DW] = DW'(j*37 + i*3 + 1);
    return a;
  endfunction

  function automatic logic [W-1:0] rnd_a();
    logic [W-1:0] a = '0;
    for (int i = 0; i < N*N; i++)
      a[i*DW +: DW] = DW'($urandom);
    return a;
  endfunction

  function automatic logic [W-1:0] ref_t(logic [W-1:0] a, int s);
    logic [W-1:0] e = '0;
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++)
        e[(r*N+c)*DW +: DW] = a[(c*N+r)*DW +: DW];
    return e;
  endfunction

  // Monitor: every done pulse pops one expectation and compares it.
  always @(negedge clk) begin
    if (!rst && done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk_vec("C_flat", C_flat, mon_e.c);
        chk_int("size_err", int'(size_err), int'(mon_e.err));
        chk_int("done_cycle", cyc, mon_e.due);
        chk_int("busy_at_done", int'(busy), 1);
      end
    end
  end

  // Watchdog
  always @(posedge clk) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog: got cycle %0d expected finish before 60000", cyc);
      $fatal(1, "timeout");
    end
  end

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || done) && t < 300);
    if (busy || done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  // Issue one request from a negedge; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input int s, input logic [W-1:0] expc,
                       input logic experr, input bit push);
    int k;
    start  = 1'b1;
    A_flat = a;
    size   = SW'(s);
    @(posedge clk);
    #1;
    k = cyc;
    if (push) begin
      accepts++;
      exp_q.push_back('{c: expc, err: experr, due: k + (experr ? 0 : s*s)});
    end
    start  = 1'b0;
    A_flat = rnd_a();
    size   = SW'($urandom);
  endtask

  initial begin
    int k;
    int s;
    logic [W-1:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_vec("reset_C", C_flat, '0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    chk_int("reset_err", int'(size_err), 0);

    // Full 5x5; start offered in the very first cycle with rst low
    @(negedge clk);
    rst = 1'b0;
    issue(lin_a(), 5, lin_exp(5), 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk_vec("hold_C", C_flat, lin_exp(5));
    chk_int("hold_busy", int'(busy), 0);

    // 3x3 window, outside bytes must be zero
    issue(lin_a(), 3, lin_exp(3), 1'b0, 1'b1);
    wait_idle();

    // Illegal sizes
    issue(lin_a(), 0, '0, 1'b1, 1'b1);
    wait_idle();
    chk_int("err0_busy", int'(busy), 0);
    chk_int("err0_held", int'(size_err), 1);
    issue(lin_a(), 6, '0, 1'b1, 1'b1);
    wait_idle();
    chk_int("err6_busy", int'(busy), 0);
    chk_int("err6_held", int'(size_err), 1);
    chk_vec("err6_C", C_flat, '0);

    // Reset in the 10th COPY cycle aborts without done
    issue(lin_a(), 5, '0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_vec("abort_C", C_flat, '0);
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_done", int'(done), 0);
    chk_int("abort_err", int'(size_err), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(lin_a(), 5, lin_exp(5), 1'b0, 1'b1);
    wait_idle();

    // start held high, A changing every cycle, S=2
    start  = 1'b1;
    size   = SW'(2);
    A_flat = pat_a(0);
    @(posedge clk);
    #1;
    k = cyc;
    accepts += 2;
    exp_q.push_back('{c: ref_t(pat_a(0), 2), err: 1'b0, due: k + 4});
    exp_q.push_back('{c: ref_t(pat_a(6), 2), err: 1'b0, due: k + 6 + 4});
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      A_flat = pat_a(j);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Random sweep
    for (int it = 0; it < 1000; it++) begin
      a = rnd_a();
      s = int'($urandom_range(1, N));
      issue(a, s, ref_t(a, s), 1'b0, 1'b1);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    chk_int("done_count", dones, accepts);
    chk_int("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
